mem_arbiter: RTL

- Shares the single data memory port (ram) between the fetch stage (instruction reads) and the execute/memory stage (loads/stores).
- Arbitrates, registers the winning request, holds it on the memory port until the memory accepts it, then returns data and a one-cycle ready pulse to the winner.
- Data side has priority to keep the pipeline draining; a streak limit stops instruction fetch from starving.

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one memory port between instruction fetch and data access.
// Optional wait-state timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

    state_t     state;
    state_t     state_next;
    logic [2:0] streak;
    logic       take_d;
    logic       take_i;
    logic       finish;
    logic       expire;

    generate
        if (MAX_D_STREAK < 1 || MAX_D_STREAK > 7 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("mem_arbiter: parameter out of range");
        end
    endgenerate

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data wins unless fetch has been waiting through a full streak of data grants.
    always_comb begin
        state_next = state;
        take_d     = 1'b0;
        take_i     = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && streak == STREAK_MAX)) begin
                    take_d     = 1'b1;
                    state_next = ACCESS;
                end else if (i_req) begin
                    take_i     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt == WAIT_LIMIT) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            grant_d   <= 1'b0;
            streak    <= '0;
            i_rdata   <= '0;
            i_ready   <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
        end else begin
            if (take_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
                grant_d   <= 1'b1;
                if (!i_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 3'd1;
                end
            end else if (take_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                grant_d   <= 1'b0;
                streak    <= '0;
            end

            // Completion or timeout releases the port and answers only the owner.
            if (finish || expire) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                if (grant_d) begin
                    d_rdata <= (expire || mem_we) ? '0 : mem_rdata;
                    d_ready <= 1'b1;
                end else begin
                    i_rdata <= expire ? '0 : mem_rdata;
                    i_ready <= 1'b1;
                end
            end

            if (state == RESP) begin
                i_ready <= 1'b0;
                d_ready <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Wait counter restarts with every new grant and counts stalled ACCESS cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            if (take_d || take_i) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (expire) begin
                if (grant_d) begin
                    d_err <= 1'b1;
                end else begin
                    i_err <= 1'b1;
                end
            end else if (state == RESP) begin
                i_err <= 1'b0;
                d_err <= 1'b0;
            end
        end
    end
`else
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule
